urna_coletor: RTL and testbench
===============================

# urna_coletor

Ballot-collection front end feeding the vote-tally block. Accepts one popular ballot per cycle over a valid/ready handshake and keeps a saturating 6-bit count per candidate (VA..VD). After the poll is closed it latches the four judge votes (J1..J4), then raises `paraoif` to start the tally decision. All tally-side outputs are registered and stable while `paraoif` is high.

## Interface
- `W_VOTO`, 6: width of each per-candidate count; saturates at 2^W_VOTO-1.
- `W_TOTAL`, 8: width of the total-accepted-ballots counter; saturates.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `abrir` in 1: open a new election; clears all counts and judge votes.
- `fechar` in 1: close popular polling and start judge collection.
- `voto_valido` in 1: ballot present.
- `voto_cand` in 2: candidate code (00=A, 01=B, 10=C, 11=D).
- `voto_pronto` out 1: ballot accepted this cycle when high with `voto_valido`.
- `juiz_valido` in 1: judge vote present.
- `juiz_id` in 2: judge index (00=J1 .. 11=J4).
- `juiz_voto` in 2: candidate code chosen by that judge.
- `juiz_pronto` out 1: judge vote accepted this cycle when high with `juiz_valido`.
- `VA`, `VB`, `VC`, `VD` out W_VOTO: per-candidate ballot counts.
- `J1`, `J2`, `J3`, `J4` out 2: latched judge votes.
- `total_votos` out W_TOTAL: ballots accepted.
- `saturou` out 1: sticky flag; some count hit its maximum with a ballot still arriving.
- `paraoif` out 1: collection complete; tally inputs valid.
- `estado` out 2: current FSM state, for debug.

## Operation
- FSM states: OCIOSO (00), COLETA (01), JULGAMENTO (10), FECHADO (11).
- OCIOSO: no acceptance. `abrir` → COLETA.
- COLETA: `voto_pronto`=1.
  - An accepted ballot increments the selected candidate count and `total_votos`.
  - `fechar` → JULGAMENTO. `abrir` is ignored.
- JULGAMENTO: `voto_pronto`=0.
  - `juiz_pronto` = `juiz_valido` and judge `juiz_id` has not yet voted.
  - An accepted vote latches `juiz_voto` into J[`juiz_id`+1] and sets that judge's voted bit.
  - A duplicate vote from the same judge is refused (`juiz_pronto`=0) and the first value is kept.
  - When the fourth distinct judge is accepted → FECHADO.
- FECHADO: `paraoif`=1, all outputs frozen. `abrir` → COLETA, clears counts, J1..J4, voted bits and `saturou`.
- Saturation: a count at 2^W_VOTO-1 stays there on further ballots and sets `saturou`. `total_votos` saturates independently and does not set `saturou`.
- `abrir` in COLETA or JULGAMENTO has no effect. `fechar` outside COLETA has no effect.
- Simultaneous events:
  - Ballot accepted and `fechar` in the same cycle: the ballot is counted, then the FSM transitions.
  - `abrir` and `fechar` together in FECHADO: `abrir` wins; the next state is COLETA.
- `rst` at any point, including mid-collection: next cycle is OCIOSO with every output zero.

## Timing
- Reset value of all outputs is 0; `estado`=OCIOSO.
- `voto_pronto`, `juiz_pronto` and `paraoif` are combinational from state and inputs. `paraoif` is a pure decode of `estado`.
- A count update is visible on the cycle after acceptance (1-cycle latency). Back-to-back ballots are accepted every cycle.
- `paraoif` rises in the cycle after the fourth judge vote is accepted. It stays high until `abrir` or `rst`.
- After `abrir`, counts read 0 on the next cycle, and ballots are accepted from that cycle on.

## Structure
- Package `urna_pkg` holds:
  - candidate codes CAND_A..CAND_D;
  - FSM state encoding;
  - default widths.
- Sub-module `contador_sat`: W-bit saturating counter with `clr`, `inc` and `sat` outputs.
  - Instantiated 4× for VA..VD and once for `total_votos`.
  - The top level contains the FSM, judge latches and voted-bit mask.

## Test plan
- Reset, `abrir`, then ballots A×17, B×15, C×15, D×53, `fechar`, judges J1..J3=10 and J4=00 → VA=17, VB=15, VC=15, VD=53, J1..J3=2'b10, J4=2'b00, `paraoif`=1 one cycle after the J4 vote, `total_votos`=100.
- 70 ballots for A → VA=63 and `saturou`=1; `total_votos`=70; other counts 0.
- In JULGAMENTO: J2 votes 01, then J2 votes 11 → second vote refused (`juiz_pronto`=0), J2 stays 01, FSM stays JULGAMENTO.
- Ballot for C and `fechar` in the same cycle → VC increments by 1, `estado`=JULGAMENTO, then `voto_valido` is refused.
- `rst` mid-COLETA with VB=9 → next cycle all outputs 0, `estado`=OCIOSO, and ballots are refused until `abrir`.
- `abrir` in FECHADO → `paraoif`=0, all counts and J1..J4 read 0, `estado`=COLETA on the next cycle.

Source files
------------

// File: rtl/urna_pkg.sv
// Shared encodings and default widths for the ballot-collection front end.
package urna_pkg;
  localparam int W_VOTO_DEF  = 6;
  localparam int W_TOTAL_DEF = 8;
  localparam int N_CAND      = 4;
  localparam int N_JUIZ      = 4;

  typedef enum logic [1:0] {
    CAND_A = 2'b00,
    CAND_B = 2'b01,
    CAND_C = 2'b10,
    CAND_D = 2'b11
  } cand_e;

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    COLETA     = 2'b01,
    JULGAMENTO = 2'b10,
    FECHADO    = 2'b11
  } estado_e;
endpackage

// File: rtl/contador_sat.sv
// W-bit saturating up-counter with synchronous clear; sat flags the all-ones value.
module contador_sat #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);
  logic [W-1:0] q_q, q_d;

  assign sat = (q_q == {W{1'b1}});
  assign q   = q_q;

  always_comb begin
    q_d = q_q;
    if (clr)             q_d = '0;
    else if (inc && !sat) q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end
endmodule

// File: rtl/urna_coletor.sv
// Ballot collector: counts popular ballots per candidate, then latches four
// distinct judge votes and raises paraoif for the tally stage.
module urna_coletor
  import urna_pkg::*;
#(
  parameter int W_VOTO  = W_VOTO_DEF,
  parameter int W_TOTAL = W_TOTAL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abrir,
  input  logic               fechar,
  input  logic               voto_valido,
  input  logic [1:0]         voto_cand,
  output logic               voto_pronto,
  input  logic               juiz_valido,
  input  logic [1:0]         juiz_id,
  input  logic [1:0]         juiz_voto,
  output logic               juiz_pronto,
  output logic [W_VOTO-1:0]  VA,
  output logic [W_VOTO-1:0]  VB,
  output logic [W_VOTO-1:0]  VC,
  output logic [W_VOTO-1:0]  VD,
  output logic [1:0]         J1,
  output logic [1:0]         J2,
  output logic [1:0]         J3,
  output logic [1:0]         J4,
  output logic [W_TOTAL-1:0] total_votos,
  output logic               saturou,
  output logic               paraoif,
  output logic [1:0]         estado
);
  estado_e                             estado_q;
  logic [N_JUIZ-1:0][1:0]              j_q;
  logic [N_JUIZ-1:0]                   votou_q;
  logic                                saturou_q;

  logic [N_CAND-1:0][W_VOTO-1:0]       cnt;
  logic [N_CAND-1:0]                   cnt_sat;
  logic [N_CAND-1:0]                   inc_cand;
  logic                                aceita_voto, aceita_juiz, limpa;
  logic [N_JUIZ-1:0]                   juiz_mask;
  logic                                unused_tot_sat;

  assign voto_pronto = (estado_q == COLETA);
  assign aceita_voto = voto_pronto && voto_valido;
  assign juiz_mask   = 4'b0001 << juiz_id;
  assign juiz_pronto = (estado_q == JULGAMENTO) && juiz_valido && !votou_q[juiz_id];
  assign aceita_juiz = juiz_pronto;
  // abrir only opens an election from idle or after the judges are done
  assign limpa       = abrir && ((estado_q == OCIOSO) || (estado_q == FECHADO));

  for (genvar c = 0; c < N_CAND; c++) begin : g_cand
    assign inc_cand[c] = aceita_voto && (voto_cand == 2'(c));
    contador_sat #(.W(W_VOTO)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (limpa),
      .inc (inc_cand[c]),
      .q   (cnt[c]),
      .sat (cnt_sat[c])
    );
  end

  contador_sat #(.W(W_TOTAL)) u_total (
    .clk (clk),
    .rst (rst),
    .clr (limpa),
    .inc (aceita_voto),
    .q   (total_votos),
    .sat (unused_tot_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      j_q       <= '0;
      votou_q   <= '0;
      saturou_q <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO, FECHADO: begin
          if (abrir) begin
            estado_q  <= COLETA;
            j_q       <= '0;
            votou_q   <= '0;
            saturou_q <= 1'b0;
          end
        end
        COLETA: begin
          if (|(inc_cand & cnt_sat)) saturou_q <= 1'b1;
          if (fechar)                estado_q  <= JULGAMENTO;
        end
        JULGAMENTO: begin
          if (aceita_juiz) begin
            j_q[juiz_id]     <= juiz_voto;
            votou_q[juiz_id] <= 1'b1;
            if ((votou_q | juiz_mask) == '1) estado_q <= FECHADO;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign VA      = cnt[0];
  assign VB      = cnt[1];
  assign VC      = cnt[2];
  assign VD      = cnt[3];
  assign J1      = j_q[0];
  assign J2      = j_q[1];
  assign J3      = j_q[2];
  assign J4      = j_q[3];
  assign saturou = saturou_q;
  assign estado  = estado_q;
  assign paraoif = (estado_q == FECHADO);
endmodule

// File: tb/tb_urna_coletor.sv
// Directed bench for urna_coletor: hand-computed expectations checked with immediate assertions.
module tb_urna_coletor;
  logic       clk = 1'b0;
  logic       rst, abrir, fechar, voto_valido, juiz_valido;
  logic [1:0] voto_cand, juiz_id, juiz_voto;
  logic       voto_pronto, juiz_pronto, saturou, paraoif;
  logic [5:0] VA, VB, VC, VD;
  logic [1:0] J1, J2, J3, J4, estado;
  logic [7:0] total_votos;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  urna_coletor dut (
    .clk(clk), .rst(rst), .abrir(abrir), .fechar(fechar),
    .voto_valido(voto_valido), .voto_cand(voto_cand), .voto_pronto(voto_pronto),
    .juiz_valido(juiz_valido), .juiz_id(juiz_id), .juiz_voto(juiz_voto),
    .juiz_pronto(juiz_pronto),
    .VA(VA), .VB(VB), .VC(VC), .VD(VD),
    .J1(J1), .J2(J2), .J3(J3), .J4(J4),
    .total_votos(total_votos), .saturou(saturou), .paraoif(paraoif), .estado(estado)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    #0;
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic votos(input logic [1:0] cand, input int n);
    for (int i = 0; i < n; i++) begin
      voto_valido = 1'b1;
      voto_cand   = cand;
      tick();
    end
    voto_valido = 1'b0;
  endtask

  task automatic juiz(input logic [1:0] id, input logic [1:0] v, input logic exp_pronto);
    juiz_valido = 1'b1;
    juiz_id     = id;
    juiz_voto   = v;
    #1;
    chk("juiz_pronto", 32'(juiz_pronto), 32'(exp_pronto));
    tick();
    juiz_valido = 1'b0;
  endtask

  initial begin
    rst = 1'b1; abrir = 1'b0; fechar = 1'b0; voto_valido = 1'b0; voto_cand = 2'b00;
    juiz_valido = 1'b0; juiz_id = 2'b00; juiz_voto = 2'b00;
    tick(); tick();
    rst = 1'b0;
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_VA", 32'(VA), 32'd0);
    chk("rst_total", 32'(total_votos), 32'd0);
    chk("rst_paraoif", 32'(paraoif), 32'd0);

    // idle: ballots refused
    voto_valido = 1'b1; #1;
    chk("idle_voto_pronto", 32'(voto_pronto), 32'd0);
    tick();
    voto_valido = 1'b0;
    chk("idle_VA", 32'(VA), 32'd0);

    abrir = 1'b1; tick(); abrir = 1'b0;
    chk("abrir_estado", 32'(estado), 32'd1);
    chk("abrir_voto_pronto", 32'(voto_pronto), 32'd1);

    // main election
    votos(2'b00, 17); votos(2'b01, 15); votos(2'b10, 15); votos(2'b11, 53);
    chk("main_VA", 32'(VA), 32'd17);
    chk("main_VB", 32'(VB), 32'd15);
    chk("main_VC", 32'(VC), 32'd15);
    chk("main_VD", 32'(VD), 32'd53);
    chk("main_total", 32'(total_votos), 32'd100);
    chk("main_saturou", 32'(saturou), 32'd0);
    fechar = 1'b1; tick(); fechar = 1'b0;
    chk("fechar_estado", 32'(estado), 32'd2);
    juiz(2'd0, 2'b10, 1'b1);
    juiz(2'd1, 2'b10, 1'b1);
    juiz(2'd2, 2'b10, 1'b1);
    chk("pre_j4_paraoif", 32'(paraoif), 32'd0);
    juiz(2'd3, 2'b00, 1'b1);
    chk("paraoif", 32'(paraoif), 32'd1);
    chk("fechado_estado", 32'(estado), 32'd3);
    chk("J1", 32'(J1), 32'd2);
    chk("J2", 32'(J2), 32'd2);
    chk("J3", 32'(J3), 32'd2);
    chk("J4", 32'(J4), 32'd0);

    // frozen in FECHADO
    voto_valido = 1'b1; #1;
    chk("fechado_voto_pronto", 32'(voto_pronto), 32'd0);
    tick(); voto_valido = 1'b0;
    chk("fechado_VA", 32'(VA), 32'd17);
    chk("fechado_total", 32'(total_votos), 32'd100);

    // abrir + fechar together in FECHADO: abrir wins
    abrir = 1'b1; fechar = 1'b1; tick(); abrir = 1'b0; fechar = 1'b0;
    chk("reabrir_estado", 32'(estado), 32'd1);
    chk("reabrir_paraoif", 32'(paraoif), 32'd0);
    chk("reabrir_VD", 32'(VD), 32'd0);
    chk("reabrir_J1", 32'(J1), 32'd0);
    chk("reabrir_total", 32'(total_votos), 32'd0);

    // saturation
    votos(2'b00, 70);
    chk("sat_VA", 32'(VA), 32'd63);
    chk("sat_saturou", 32'(saturou), 32'd1);
    chk("sat_total", 32'(total_votos), 32'd70);
    chk("sat_VB", 32'(VB), 32'd0);

    // ballot and fechar in the same cycle
    voto_valido = 1'b1; voto_cand = 2'b10; fechar = 1'b1;
    tick(); fechar = 1'b0;
    chk("same_VC", 32'(VC), 32'd1);
    chk("same_estado", 32'(estado), 32'd2);
    #1;
    chk("julg_voto_pronto", 32'(voto_pronto), 32'd0);
    tick(); voto_valido = 1'b0;
    chk("julg_VC", 32'(VC), 32'd1);
    chk("julg_total", 32'(total_votos), 32'd71);

    abrir = 1'b1; tick(); abrir = 1'b0;
    chk("julg_abrir_estado", 32'(estado), 32'd2);
    chk("julg_abrir_VA", 32'(VA), 32'd63);

    // duplicate judge vote
    juiz(2'd1, 2'b01, 1'b1);
    chk("dup_J2_first", 32'(J2), 32'd1);
    juiz(2'd1, 2'b11, 1'b0);
    chk("dup_J2_kept", 32'(J2), 32'd1);
    chk("dup_estado", 32'(estado), 32'd2);

    // reset mid-collection
    rst = 1'b1; tick(); rst = 1'b0;
    abrir = 1'b1; tick(); abrir = 1'b0;
    votos(2'b01, 9);
    chk("pre_rst_VB", 32'(VB), 32'd9);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_estado", 32'(estado), 32'd0);
    chk("mid_rst_VB", 32'(VB), 32'd0);
    chk("mid_rst_total", 32'(total_votos), 32'd0);
    chk("mid_rst_saturou", 32'(saturou), 32'd0);
    chk("mid_rst_J2", 32'(J2), 32'd0);
    voto_valido = 1'b1; voto_cand = 2'b01; #1;
    chk("mid_rst_voto_pronto", 32'(voto_pronto), 32'd0);
    tick(); voto_valido = 1'b0;
    chk("mid_rst_VB_refused", 32'(VB), 32'd0);

    // fechar outside COLETA ignored
    fechar = 1'b1; tick(); fechar = 1'b0;
    chk("idle_fechar_estado", 32'(estado), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
